// File: rtl/sdio_bus_arb.sv
// Two-master round-robin arbiter for the byte-wide DMA memory bus, with bounded
// bursts and an in-order tag FIFO that routes read data back to the issuing master.
module sdio_bus_arb #(
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned RD_DEPTH  = 4
) (
    input  logic              bus_clk,
    input  logic              rstn,
    input  logic              m0_bus_rd,
    input  logic              m0_bus_wr,
    input  logic [ADDR_W-1:0] m0_bus_addr,
    input  logic [DATA_W-1:0] m0_bus_wdata,
    output logic              m0_bus_ready,
    output logic              m0_bus_rdata_ready,
    output logic [DATA_W-1:0] m0_bus_rdata,
    input  logic              m1_bus_rd,
    input  logic              m1_bus_wr,
    input  logic [ADDR_W-1:0] m1_bus_addr,
    input  logic [DATA_W-1:0] m1_bus_wdata,
    output logic              m1_bus_ready,
    output logic              m1_bus_rdata_ready,
    output logic [DATA_W-1:0] m1_bus_rdata,
    output logic              s_bus_rd,
    output logic              s_bus_wr,
    output logic [ADDR_W-1:0] s_bus_addr,
    output logic [DATA_W-1:0] s_bus_wdata,
    input  logic              s_bus_ready,
    input  logic              s_bus_rdata_ready,
    input  logic [DATA_W-1:0] s_bus_rdata,
    output logic [1:0]        owner,
    output logic              rsp_err
);

    localparam int unsigned PTR_W  = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                last_owner_q, last_owner_d;   // 1: m1 held the bus last
    logic [BEAT_W-1:0]   beat_q, beat_d, beat_inc;
    logic [RD_DEPTH-1:0] tag_q;
    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                rsp_err_q;

    logic              m0_req, m1_req;
    logic              own_rd, own_wr, own_req, oth_req;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              fifo_full, fifo_empty, gate, fwd, accept;
    logic              push, pop, head;

    assign m0_req = m0_bus_rd | m0_bus_wr;
    assign m1_req = m1_bus_rd | m1_bus_wr;

    always_comb begin
        own_rd    = 1'b0;
        own_wr    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        oth_req   = 1'b0;
        unique case (state_q)
            GNT0: begin
                own_rd    = m0_bus_rd;
                own_wr    = m0_bus_wr;
                own_addr  = m0_bus_addr;
                own_wdata = m0_bus_wdata;
                oth_req   = m1_req;
            end
            GNT1: begin
                own_rd    = m1_bus_rd;
                own_wr    = m1_bus_wr;
                own_addr  = m1_bus_addr;
                own_wdata = m1_bus_wdata;
                oth_req   = m0_req;
            end
            default: ;
        endcase
    end

    assign own_req    = own_rd | own_wr;
    assign fifo_full  = (cnt_q == CNT_W'(RD_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign gate       = !(fifo_full && own_rd);
    assign fwd        = (state_q != IDLE) && gate;
    assign accept     = fwd && own_req && s_bus_ready;

    assign s_bus_rd    = fwd & own_rd;
    assign s_bus_wr    = fwd & own_wr;
    assign s_bus_addr  = fwd ? own_addr  : '0;
    assign s_bus_wdata = fwd ? own_wdata : '0;

    assign m0_bus_ready = accept && (state_q == GNT0);
    assign m1_bus_ready = accept && (state_q == GNT1);

    assign push = accept & own_rd;
    assign pop  = s_bus_rdata_ready & !fifo_empty;
    assign head = tag_q[rptr_q];

    assign m0_bus_rdata_ready = pop & !head;
    assign m1_bus_rdata_ready = pop &  head;
    assign m0_bus_rdata       = s_bus_rdata;
    assign m1_bus_rdata       = s_bus_rdata;

    assign owner   = state_q;
    assign rsp_err = rsp_err_q;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        beat_d       = beat_q;
        beat_inc     = beat_q + BEAT_W'(1);
        unique case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = last_owner_q ? GNT0 : GNT1;
                end else if (m0_req) begin
                    state_d = GNT0;
                end else if (m1_req) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!own_req) begin
                    state_d      = IDLE;
                    last_owner_d = (state_q == GNT1);
                    beat_d       = '0;
                end else if (accept) begin
                    if (beat_inc == BEAT_W'(MAX_BURST)) begin
                        beat_d = '0;
                        if (oth_req) begin
                            state_d      = (state_q == GNT0) ? GNT1 : GNT0;
                            last_owner_d = (state_q == GNT1);
                        end
                    end else begin
                        beat_d = beat_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            beat_q       <= beat_d;
        end
    end

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            tag_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wptr_q] <= (state_q == GNT1);
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (s_bus_rdata_ready && fifo_empty) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdio_bus_arb.sv
// Scoreboard bench for sdio_bus_arb: randomized masters and slave, a transaction-level
// reference of acceptance, read routing and error flagging, plus directed arbitration scenarios.
module tb_sdio_bus_arb;

    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 16;
    localparam int RD_DEPTH  = 4;

    logic              bus_clk;
    logic              rstn;
    logic              m0_bus_rd, m0_bus_wr, m1_bus_rd, m1_bus_wr;
    logic [ADDR_W-1:0] m0_bus_addr, m1_bus_addr;
    logic [DATA_W-1:0] m0_bus_wdata, m1_bus_wdata;
    logic              m0_bus_ready, m1_bus_ready;
    logic              m0_bus_rdata_ready, m1_bus_rdata_ready;
    logic [DATA_W-1:0] m0_bus_rdata, m1_bus_rdata;
    logic              s_bus_rd, s_bus_wr;
    logic [ADDR_W-1:0] s_bus_addr;
    logic [DATA_W-1:0] s_bus_wdata;
    logic              s_bus_ready, s_bus_rdata_ready;
    logic [DATA_W-1:0] s_bus_rdata;
    logic [1:0]        owner;
    logic              rsp_err;

    sdio_bus_arb #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST),
        .RD_DEPTH (RD_DEPTH)
    ) dut (
        .bus_clk           (bus_clk),
        .rstn              (rstn),
        .m0_bus_rd         (m0_bus_rd),
        .m0_bus_wr         (m0_bus_wr),
        .m0_bus_addr       (m0_bus_addr),
        .m0_bus_wdata      (m0_bus_wdata),
        .m0_bus_ready      (m0_bus_ready),
        .m0_bus_rdata_ready(m0_bus_rdata_ready),
        .m0_bus_rdata      (m0_bus_rdata),
        .m1_bus_rd         (m1_bus_rd),
        .m1_bus_wr         (m1_bus_wr),
        .m1_bus_addr       (m1_bus_addr),
        .m1_bus_wdata      (m1_bus_wdata),
        .m1_bus_ready      (m1_bus_ready),
        .m1_bus_rdata_ready(m1_bus_rdata_ready),
        .m1_bus_rdata      (m1_bus_rdata),
        .s_bus_rd          (s_bus_rd),
        .s_bus_wr          (s_bus_wr),
        .s_bus_addr        (s_bus_addr),
        .s_bus_wdata       (s_bus_wdata),
        .s_bus_ready       (s_bus_ready),
        .s_bus_rdata_ready (s_bus_rdata_ready),
        .s_bus_rdata       (s_bus_rdata),
        .owner             (owner),
        .rsp_err           (rsp_err)
    );

    typedef struct {
        bit                rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;
    typedef struct {
        int                m;
        logic [DATA_W-1:0] data;
    } resp_t;
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } slv_t;

    txn_t  dq0[$], dq1[$];           // driver work lists
    txn_t  exp_req0[$], exp_req1[$]; // expected slave-side view per master
    resp_t resp_q[$];                // reads outstanding, in acceptance order
    slv_t  slv_q[$];
    int    acc_m[$], acc_cyc[$], resp_m[$], resp_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit exp_err;
    bit slave_rand;
    bit gaps;
    int dmin, dmax;
    int spur_req;

    function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (lo * 8'd7) ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
    endtask

    initial begin
        bus_clk = 1'b0;
        forever #5 bus_clk = ~bus_clk;
    end

    initial forever begin
        @(posedge bus_clk);
        cyc++;
    end

    task automatic drive(input int m);
        txn_t t;
        bit   have;
        int   idle;
        idle = 0;
        t    = '{0, '0, '0};
        forever begin
            have = (m == 0) ? (dq0.size() > 0) : (dq1.size() > 0);
            if (idle > 0) begin
                idle--;
                have = 1'b0;
            end
            if (have) t = (m == 0) ? dq0[0] : dq1[0];
            if (m == 0) begin
                m0_bus_rd    = have &&  t.rd;
                m0_bus_wr    = have && !t.rd;
                m0_bus_addr  = have ? t.addr : '0;
                m0_bus_wdata = have ? t.data : '0;
            end else begin
                m1_bus_rd    = have &&  t.rd;
                m1_bus_wr    = have && !t.rd;
                m1_bus_addr  = have ? t.addr : '0;
                m1_bus_wdata = have ? t.data : '0;
            end
            @(negedge bus_clk);
            if (have && rstn) begin
                if (m == 0 && m0_bus_ready && dq0.size() > 0) begin
                    void'(dq0.pop_front());
                    if (gaps) idle = int'($urandom_range(0, 2));
                end
                if (m == 1 && m1_bus_ready && dq1.size() > 0) begin
                    void'(dq1.pop_front());
                    if (gaps) idle = int'($urandom_range(0, 2));
                end
            end
            @(posedge bus_clk);
            #1;
        end
    endtask

    initial drive(0);
    initial drive(1);

    // Slave: random or constant ready, returns reads in order after a configurable delay.
    initial begin
        int   spur_done, last_due, due;
        bit   real_resp;
        slv_t s;
        spur_done = 0;
        last_due  = 0;
        s_bus_ready       = 1'b1;
        s_bus_rdata_ready = 1'b0;
        s_bus_rdata       = '0;
        forever begin
            @(posedge bus_clk);
            #1;
            s_bus_ready       = slave_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
            s_bus_rdata_ready = 1'b0;
            s_bus_rdata       = DATA_W'($urandom);
            real_resp         = 1'b0;
            if (spur_req != spur_done) begin
                spur_done++;
                s_bus_rdata_ready = 1'b1;
            end else if (slv_q.size() > 0 && slv_q[0].due <= cyc) begin
                s_bus_rdata_ready = 1'b1;
                s_bus_rdata       = slv_q[0].data;
                real_resp         = 1'b1;
            end
            @(negedge bus_clk);
            if (real_resp) void'(slv_q.pop_front());
            if (s_bus_ready && s_bus_rd) begin
                due = cyc + int'($urandom_range(dmin, dmax));
                if (due < last_due) due = last_due;
                last_due = due;
                s.due  = due;
                s.data = mem_val(s_bus_addr);
                slv_q.push_back(s);
            end
        end
    end

    task automatic monitor_step();
        logic              o_rd, o_wr, fwd, exp_rdy, spur;
        logic [ADDR_W-1:0] o_addr;
        int                outs, m;
        txn_t              t;
        resp_t             e;
        outs   = resp_q.size();
        o_rd   = 1'b0;
        o_wr   = 1'b0;
        o_addr = '0;
        spur   = 1'b0;
        if (owner == 2'b01) begin
            o_rd = m0_bus_rd; o_wr = m0_bus_wr; o_addr = m0_bus_addr;
        end else if (owner == 2'b10) begin
            o_rd = m1_bus_rd; o_wr = m1_bus_wr; o_addr = m1_bus_addr;
        end
        fwd     = (owner == 2'b01 || owner == 2'b10) && !(o_rd && outs >= RD_DEPTH);
        exp_rdy = fwd && (o_rd || o_wr) && s_bus_ready;
        chk("owner_legal", 32'(owner == 2'b11), 0);
        chk("m0_ready", 32'(m0_bus_ready), 32'(exp_rdy && owner == 2'b01));
        chk("m1_ready", 32'(m1_bus_ready), 32'(exp_rdy && owner == 2'b10));
        chk("s_bus_rd", 32'(s_bus_rd), 32'(fwd && o_rd));
        chk("s_bus_wr", 32'(s_bus_wr), 32'(fwd && o_wr));
        chk("s_bus_addr", 32'(s_bus_addr), fwd ? 32'(o_addr) : 32'd0);

        if (m0_bus_ready || m1_bus_ready) begin
            m = m1_bus_ready ? 1 : 0;
            if ((m == 0 && exp_req0.size() == 0) || (m == 1 && exp_req1.size() == 0)) begin
                fail_now("unexpected_accept", $sformatf("master %0d accepted with nothing issued", m));
            end else begin
                if (m == 0) t = exp_req0.pop_front();
                else        t = exp_req1.pop_front();
                chk("acc_rd", 32'(s_bus_rd), 32'(t.rd));
                chk("acc_wr", 32'(s_bus_wr), 32'(!t.rd));
                chk("acc_addr", 32'(s_bus_addr), 32'(t.addr));
                if (!t.rd) chk("acc_wdata", 32'(s_bus_wdata), 32'(t.data));
                if (t.rd) resp_q.push_back('{m, mem_val(t.addr)});
                acc_m.push_back(m);
                acc_cyc.push_back(cyc);
            end
        end

        if (s_bus_rdata_ready) begin
            if (outs == 0) begin
                chk("spur_m0_rdy", 32'(m0_bus_rdata_ready), 0);
                chk("spur_m1_rdy", 32'(m1_bus_rdata_ready), 0);
                spur = 1'b1;
            end else begin
                e = resp_q.pop_front();
                chk("route_m0", 32'(m0_bus_rdata_ready), 32'(e.m == 0));
                chk("route_m1", 32'(m1_bus_rdata_ready), 32'(e.m == 1));
                chk("rdata", 32'((e.m == 0) ? m0_bus_rdata : m1_bus_rdata), 32'(e.data));
                resp_m.push_back(e.m);
                resp_cyc.push_back(cyc);
            end
        end else begin
            chk("rdata_rdy_idle", 32'({m0_bus_rdata_ready, m1_bus_rdata_ready}), 0);
        end
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        if (spur) exp_err = 1'b1;
    endtask

    initial forever begin
        @(negedge bus_clk);
        if (rstn) monitor_step();
    end

    task automatic issue(input int m, input bit rd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        txn_t t;
        t.rd = rd; t.addr = a; t.data = d;
        if (m == 0) begin dq0.push_back(t); exp_req0.push_back(t); end
        else        begin dq1.push_back(t); exp_req1.push_back(t); end
    endtask

    task automatic clear_logs();
        acc_m.delete(); acc_cyc.delete(); resp_m.delete(); resp_cyc.delete();
    endtask

    task automatic clear_model();
        dq0.delete(); dq1.delete(); exp_req0.delete(); exp_req1.delete();
        resp_q.delete();
        exp_err = 1'b0;
        clear_logs();
    endtask

    task automatic do_reset();
        @(posedge bus_clk);
        #2;
        rstn = 1'b0;
        clear_model();
        repeat (2) @(posedge bus_clk);
        #3;
        rstn = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge bus_clk);
            if (dq0.size() == 0 && dq1.size() == 0 && slv_q.size() == 0 && resp_q.size() == 0) break;
        end
        if (i == budget) fail_now(name, "drain timeout");
        repeat (3) @(posedge bus_clk);
        #2;
        chk({name, "_exp_left"}, 32'(exp_req0.size() + exp_req1.size()), 0);
    endtask

    initial begin
        int n0, first, wait_i;
        rstn       = 1'b0;
        exp_err    = 1'b0;
        slave_rand = 1'b0;
        gaps       = 1'b0;
        dmin       = 2;
        dmax       = 2;
        spur_req   = 0;

        do_reset();
        #1;
        chk("reset_owner", 32'(owner), 0);
        chk("reset_rsp_err", 32'(rsp_err), 0);
        chk("reset_s_rd_wr", 32'({s_bus_rd, s_bus_wr}), 0);

        // Single master writes 0x10..0x13
        @(negedge bus_clk);
        for (int i = 0; i < 4; i++) issue(0, 1'b0, ADDR_W'(32'h10 + i), DATA_W'($urandom));
        @(posedge bus_clk); #2;
        chk("t1_owner_pre_grant", 32'(owner), 0);
        chk("t1_s_wr_pre_grant", 32'(s_bus_wr), 0);
        @(posedge bus_clk); #2;
        chk("t1_owner_granted", 32'(owner), 32'h1);
        wait_drain("t1", 200);
        chk("t1_accepts", 32'(acc_m.size()), 4);
        n0 = 0;
        foreach (acc_m[i]) if (acc_m[i] == 0) n0++;
        chk("t1_m0_accepts", 32'(n0), 4);
        if (acc_cyc.size() == 4) chk("t1_back_to_back", 32'(acc_cyc[3] - acc_cyc[0]), 3);

        // Tie-break from reset, then alternating full bursts
        do_reset();
        @(negedge bus_clk);
        for (int i = 0; i < 2; i++) begin
            issue(0, 1'b0, ADDR_W'(32'h20 + i), DATA_W'($urandom));
            issue(1, 1'b0, ADDR_W'(32'h30 + i), DATA_W'($urandom));
        end
        wait_drain("t2a", 200);
        chk("t2a_accepts", 32'(acc_m.size()), 4);
        if (acc_m.size() == 4) begin
            chk("t2a_order", 32'({acc_m[0][0], acc_m[1][0], acc_m[2][0], acc_m[3][0]}), 32'b0011);
        end
        @(negedge bus_clk);
        issue(0, 1'b0, ADDR_W'(32'h40), 8'h11);
        wait_drain("t2b", 200);
        clear_logs();
        @(negedge bus_clk);
        for (int i = 0; i < 40; i++) begin
            issue(0, 1'b0, ADDR_W'(32'h1000 + i), DATA_W'($urandom));
            issue(1, 1'b0, ADDR_W'(32'h2000 + i), DATA_W'($urandom));
        end
        wait_drain("t2c", 500);
        chk("t2c_accepts", 32'(acc_m.size()), 80);
        if (acc_m.size() >= 48) begin
            n0 = 0;
            for (int i = 0; i < 48; i++) begin
                if (acc_m[i] != (((i / MAX_BURST) % 2 == 0) ? 1 : 0)) n0++;
            end
            chk("t2c_burst_pattern_errs", 32'(n0), 0);
            chk("t2c_no_idle_on_switch", 32'(acc_cyc[47] - acc_cyc[0]), 47);
        end

        // Tag FIFO fills, fifth read waits for the first response
        do_reset();
        dmin = 6; dmax = 6;
        @(negedge bus_clk);
        for (int i = 0; i < 5; i++) issue(0, 1'b1, ADDR_W'(32'h40 + i), 8'h00);
        wait_drain("t3", 300);
        chk("t3_accepts", 32'(acc_m.size()), 5);
        chk("t3_responses", 32'(resp_m.size()), 5);
        if (acc_cyc.size() == 5 && resp_cyc.size() > 0) begin
            chk("t3_4th_back_to_back", 32'(acc_cyc[3] - acc_cyc[0]), 3);
            chk("t3_5th_after_pop", 32'(acc_cyc[4] - resp_cyc[0]), 1);
        end

        // Responses routed by tag across a grant change
        do_reset();
        dmin = 8; dmax = 8;
        @(negedge bus_clk);
        issue(0, 1'b1, ADDR_W'(32'h100), 8'h00);
        issue(1, 1'b1, ADDR_W'(32'h200), 8'h00);
        wait_drain("t4", 300);
        chk("t4_responses", 32'(resp_m.size()), 2);
        if (resp_m.size() == 2 && acc_cyc.size() == 2) begin
            chk("t4_route_order", 32'({resp_m[0][0], resp_m[1][0]}), 32'b01);
            chk("t4_switch_before_resp", 32'(acc_cyc[1] < resp_cyc[0]), 1);
        end

        // Spurious response sets the sticky error until reset
        do_reset();
        repeat (2) @(posedge bus_clk);
        spur_req++;
        repeat (6) @(posedge bus_clk);
        #2;
        chk("t5_err_held", 32'(rsp_err), 1);
        do_reset();
        #1;
        chk("t5_err_cleared", 32'(rsp_err), 0);

        // Reset in the middle of a burst with two reads outstanding
        dmin = 10; dmax = 10;
        @(negedge bus_clk);
        issue(0, 1'b1, ADDR_W'(32'h300), 8'h00);
        issue(0, 1'b1, ADDR_W'(32'h301), 8'h00);
        for (int i = 0; i < 10; i++) issue(0, 1'b0, ADDR_W'(32'h310 + i), DATA_W'($urandom));
        for (wait_i = 0; wait_i < 50 && acc_m.size() < 4; wait_i++) @(posedge bus_clk);
        if (acc_m.size() < 4) fail_now("t6_pre", "burst never started");
        #2;
        chk("t6_pre_wr", 32'(s_bus_wr), 1);
        chk("t6_pre_outstanding", 32'(resp_q.size()), 2);
        rstn = 1'b0;
        clear_model();
        #1;
        chk("t6_owner_async", 32'(owner), 0);
        chk("t6_s_rd_wr_async", 32'({s_bus_rd, s_bus_wr}), 0);
        repeat (2) @(posedge bus_clk);
        #3;
        rstn = 1'b1;
        wait_drain("t6", 200);
        chk("t6_no_routed_resp", 32'(resp_m.size()), 0);
        chk("t6_err_after_reset", 32'(rsp_err), 1);

        // Randomized mixed traffic
        do_reset();
        slave_rand = 1'b1;
        gaps       = 1'b1;
        dmin = 1; dmax = 5;
        @(negedge bus_clk);
        for (int i = 0; i < 60; i++) begin
            issue(0, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
            issue(1, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
        end
        wait_drain("t7", 4000);
        chk("t7_accepts", 32'(acc_m.size()), 120);
        first = 0;
        foreach (acc_m[i]) if (acc_m[i] == 1) first++;
        chk("t7_m1_accepts", 32'(first), 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
